// File: rtl/sw_mode_ctrl.sv
// Stopwatch mode controller: RUN / PAUSED / ADJ state machine with the 1 Hz count
// prescaler, the 2 Hz adjust prescaler and the digit-blink mask for adjust mode.
// Optional feature: define SW_MODE_CTRL_BLINK_EN to build the blink prescaler and
// drive blank_mask; without it blank_mask is tied to 4'b0000.
module sw_mode_ctrl #(
  parameter int unsigned ONE_HZ_DIV = 100000000,
  parameter int unsigned TWO_HZ_DIV = 50000000,
  parameter int unsigned BLINK_DIV  = 20000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause_pulse,
  input  logic       clr_pulse,
  input  logic       adj,
  input  logic       sel,
  input  logic       at_max,
  output logic       cnt_tick,
  output logic       adj_tick,
  output logic       adj_field,
  output logic       clr_out,
  output logic [1:0] mode,
  output logic [3:0] blank_mask
);

  localparam logic [31:0] OneHzLast = 32'(ONE_HZ_DIV - 1);
  localparam logic [31:0] TwoHzLast = 32'(TWO_HZ_DIV - 1);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StPaused = 2'b01,
    StAdj    = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic        latched_q, latched_d;
  logic [31:0] sec_presc_q, sec_presc_d;
  logic [31:0] adj_presc_q, adj_presc_d;
  logic        cnt_tick_q, cnt_tick_d;
  logic        adj_tick_q, adj_tick_d;
  logic        adj_field_q;
  logic        clr_out_q;

  logic sec_count, sec_wrap;
  logic adj_count, adj_wrap, adj_entry;

  // Next mode and pause_latched; a soft clear overrides any pause strobe.
  always_comb begin
    state_d   = state_q;
    latched_d = latched_q;
    if (clr_pulse) begin
      latched_d = 1'b0;
      state_d   = adj ? StAdj : StRun;
    end else begin
      case (state_q)
        StRun: begin
          if (pause_pulse) latched_d = 1'b1;
          if (adj) state_d = StAdj;
          else if (pause_pulse) state_d = StPaused;
        end
        StPaused: begin
          if (pause_pulse) latched_d = 1'b0;
          if (adj) state_d = StAdj;
          else if (pause_pulse) state_d = StRun;
        end
        StAdj: begin
          // Pause only arms/disarms where we land once adjust is released.
          if (pause_pulse) latched_d = ~latched_q;
          if (!adj) state_d = latched_d ? StPaused : StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Prescalers and tick pulses; counting is qualified by the registered mode.
  always_comb begin
    sec_count   = (state_q == StRun) && !at_max;
    sec_wrap    = sec_count && (sec_presc_q == OneHzLast);
    cnt_tick_d  = sec_wrap && !clr_pulse;
    sec_presc_d = sec_presc_q;
    if (clr_pulse || sec_wrap) sec_presc_d = '0;
    else if (sec_count)        sec_presc_d = sec_presc_q + 32'd1;

    adj_count   = (state_q == StAdj);
    adj_wrap    = adj_count && (adj_presc_q == TwoHzLast);
    adj_entry   = (state_d == StAdj) && (state_q != StAdj);
    adj_tick_d  = adj_wrap && !clr_pulse;
    adj_presc_d = adj_presc_q;
    if (clr_pulse || adj_entry || adj_wrap) adj_presc_d = '0;
    else if (adj_count)                     adj_presc_d = adj_presc_q + 32'd1;
  end

  // Mode, prescaler and pulse-output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      latched_q   <= 1'b0;
      sec_presc_q <= '0;
      adj_presc_q <= '0;
      cnt_tick_q  <= 1'b0;
      adj_tick_q  <= 1'b0;
      adj_field_q <= 1'b0;
      clr_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      latched_q   <= latched_d;
      sec_presc_q <= sec_presc_d;
      adj_presc_q <= adj_presc_d;
      cnt_tick_q  <= cnt_tick_d;
      adj_tick_q  <= adj_tick_d;
      adj_field_q <= sel;
      clr_out_q   <= clr_pulse;
    end
  end

  assign cnt_tick  = cnt_tick_q;
  assign adj_tick  = adj_tick_q;
  assign adj_field = adj_field_q;
  assign clr_out   = clr_out_q;
  assign mode      = state_q;

`ifdef SW_MODE_CTRL_BLINK_EN
  localparam logic [31:0] BlinkLast = 32'(BLINK_DIV - 1);

  logic [31:0] blink_presc_q, blink_presc_d;
  logic        blink_phase_q, blink_phase_d;
  logic [3:0]  blank_mask_q, blank_mask_d;

  // Free-running blink timebase; the mask follows next mode/field so it lines up with them.
  always_comb begin
    blink_presc_d = blink_presc_q + 32'd1;
    blink_phase_d = blink_phase_q;
    if (blink_presc_q == BlinkLast) begin
      blink_presc_d = '0;
      blink_phase_d = ~blink_phase_q;
    end
    blank_mask_d = 4'b0000;
    if ((state_d == StAdj) && blink_phase_d) blank_mask_d = sel ? 4'b1100 : 4'b0011;
  end

  // Blink timebase and mask registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_presc_q <= '0;
      blink_phase_q <= 1'b0;
      blank_mask_q  <= 4'b0000;
    end else begin
      blink_presc_q <= blink_presc_d;
      blink_phase_q <= blink_phase_d;
      blank_mask_q  <= blank_mask_d;
    end
  end

  assign blank_mask = blank_mask_q;
`else
  assign blank_mask = 4'b0000;
`endif

endmodule

// File: tb/tb_sw_mode_ctrl.sv
// Directed bench for sw_mode_ctrl with small dividers (10 / 4 / 3).
// Cycle n is the interval after the n-th rising edge following reset release;
// inputs driven during cycle n are sampled at edge n+1.
module tb_sw_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause_pulse = 1'b0;
  logic       clr_pulse = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic       at_max = 1'b0;
  logic       cnt_tick, adj_tick, adj_field, clr_out;
  logic [1:0] mode;
  logic [3:0] blank_mask;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  sw_mode_ctrl #(
    .ONE_HZ_DIV(10),
    .TWO_HZ_DIV(4),
    .BLINK_DIV (3)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .pause_pulse(pause_pulse),
    .clr_pulse  (clr_pulse),
    .adj        (adj),
    .sel        (sel),
    .at_max     (at_max),
    .cnt_tick   (cnt_tick),
    .adj_tick   (adj_tick),
    .adj_field  (adj_field),
    .clr_out    (clr_out),
    .mode       (mode),
    .blank_mask (blank_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold reset for two edges with sel high, check reset values, release mid-cycle.
  task automatic do_reset();
    rst = 1'b1;
    pause_pulse = 1'b0;
    clr_pulse = 1'b0;
    adj = 1'b0;
    sel = 1'b1;
    at_max = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_cnt_tick", 32'(cnt_tick), 32'd0);
    check("rst_adj_tick", 32'(adj_tick), 32'd0);
    check("rst_clr_out", 32'(clr_out), 32'd0);
    check("rst_adj_field", 32'(adj_field), 32'd0);
    check("rst_blank", 32'(blank_mask), 32'd0);
    sel = 1'b0;
    rst = 1'b0;
    cyc = 0;
  endtask

  // Adjust session from cycle 5 to 19 with sel=1; optional pause strobe inside ADJ.
  task automatic run_adj(input bit with_pause);
    logic [1:0] exp_mode;
    do_reset();
    sel = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      adj = (cyc >= 5) && (cyc < 20);
      pause_pulse = with_pause && (cyc == 12);
      if (cyc >= 6 && cyc <= 20) exp_mode = 2'b10;
      else if (cyc >= 21 && with_pause) exp_mode = 2'b01;
      else exp_mode = 2'b00;
      check("adj_mode", 32'(mode), 32'(exp_mode));
      check("adj_tick", 32'(adj_tick), 32'(cyc == 10 || cyc == 14 || cyc == 18));
      check("adj_field", 32'(adj_field), 32'd1);
      check("adj_cnt_tick", 32'(cnt_tick), 32'(!with_pause && cyc == 25));
    end
    adj = 1'b0;
    pause_pulse = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_mask;

    // Free running count.
    do_reset();
    for (int i = 1; i <= 35; i++) begin
      step();
      check("run_tick", 32'(cnt_tick), 32'(cyc % 10 == 0));
      check("run_mode", 32'(mode), 32'd0);
    end

    // Pause and resume keeps the fractional second.
    do_reset();
    for (int i = 1; i <= 45; i++) begin
      step();
      pause_pulse = (cyc == 14) || (cyc == 30);
      check("pause_tick", 32'(cnt_tick), 32'(cyc == 10 || cyc == 36));
      check("pause_mode", 32'(mode), (cyc >= 15 && cyc <= 30) ? 32'd1 : 32'd0);
    end
    pause_pulse = 1'b0;

    run_adj(1'b0);
    run_adj(1'b1);

    // Clear beats a coincident pause; a clear on the wrap cycle swallows the tick.
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      step();
      clr_pulse = (cyc == 7) || (cyc == 27);
      pause_pulse = (cyc == 7);
      check("clr_out", 32'(clr_out), 32'(cyc == 8 || cyc == 28));
      check("clr_tick", 32'(cnt_tick), 32'(cyc == 18 || cyc == 38));
      check("clr_mode", 32'(mode), 32'd0);
    end
    clr_pulse = 1'b0;
    pause_pulse = 1'b0;

    // Saturation at 59:59, then clear.
    do_reset();
    at_max = 1'b1;
    for (int i = 1; i <= 65; i++) begin
      step();
      clr_pulse = (cyc == 50);
      if (cyc == 50) at_max = 1'b0;
      check("sat_tick", 32'(cnt_tick), 32'(cyc == 61));
      check("sat_clr_out", 32'(clr_out), 32'(cyc == 51));
      check("sat_mode", 32'(mode), 32'd0);
    end
    clr_pulse = 1'b0;

    // Blink mask in adjust mode; field switches to minutes at cycle 12.
    do_reset();
    adj = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      sel = (cyc >= 12);
`ifdef SW_MODE_CTRL_BLINK_EN
      if ((cyc / 3) % 2 == 1) exp_mask = (cyc >= 13) ? 4'b1100 : 4'b0011;
      else exp_mask = 4'b0000;
`else
      exp_mask = 4'b0000;
`endif
      check("blink_mask", 32'(blank_mask), 32'(exp_mask));
      check("blink_mode", 32'(mode), 32'd2);
      check("blink_field", 32'(adj_field), 32'(cyc >= 13));
    end
    adj = 1'b0;
    sel = 1'b0;

    // Reset mid-operation abandons a pending tick and acts without a clock edge.
    do_reset();
    sel = 1'b1;
    for (int i = 1; i <= 9; i++) step();
    check("mid_field_pre", 32'(adj_field), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_field_async", 32'(adj_field), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("mid_tick_in_rst", 32'(cnt_tick), 32'd0);
    end
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step();
      check("mid_tick_after", 32'(cnt_tick), 32'(cyc == 10));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
